// File: rtl/rv32_mem_pkg.sv
// Shared types and default widths for the unified instruction/data memory arbiter.
package rv32_mem_pkg;

  localparam int unsigned RV32_ADDR_W = 32;
  localparam int unsigned RV32_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } mem_owner_t;

endpackage

// File: rtl/rv32_starve_counter.sv
// Saturating wait counter: counts consecutive denied fetch cycles and flags the limit.
module rv32_starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one single-ported synchronous RAM between fetch and load/store ports:
// data-over-fetch priority with a starvation override, and read-return routing.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = RV32_ADDR_W,
  parameter int unsigned DATA_W       = RV32_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_read,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              conflict,
  output logic              mem_enable,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_owner_t owner_q;
  mem_owner_t owner_d;
  logic       force_i;
  logic       gnt_i_raw;
  logic       gnt_d_raw;
  logic       en_raw;

  rv32_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!i_req || gnt_i_raw),
    .inc      (i_req && !gnt_i_raw),
    .at_limit (force_i)
  );

  // Grant decision, memory mux and response-owner next state.
  always_comb begin
    gnt_d_raw = 1'b0;
    gnt_i_raw = 1'b0;
    en_raw    = 1'b0;
    mem_read  = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;

    gnt_d_raw = d_req && !(force_i && i_req);
    gnt_i_raw = i_req && !gnt_d_raw;

    if (gnt_d_raw) begin
      en_raw    = 1'b1;
      mem_read  = d_read;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      owner_d   = d_read ? OWN_D : OWN_NONE;
    end else if (gnt_i_raw) begin
      en_raw    = 1'b1;
      mem_addr  = i_addr;
      owner_d   = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Reset masks the externally visible handshakes without touching flopped paths.
  assign d_gnt      = gnt_d_raw && rst_n;
  assign i_gnt      = gnt_i_raw && rst_n;
  assign mem_enable = en_raw && rst_n;
  assign conflict   = i_req && d_req;

  assign i_rvalid = (owner_q == OWN_I);
  assign d_rvalid = (owner_q == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Randomised scoreboard bench for rv32_mem_arbiter with a behavioural RAM and reference model.
module tb_rv32_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_read = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        conflict;
  logic        mem_enable;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ram [256];
  logic [31:0] shadow [256];
  exp_t        iq[$];
  exp_t        dq[$];
  int unsigned cyc = 0;
  int          fetch_waited = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  rv32_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_read     (d_read),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .conflict   (conflict),
    .mem_enable (mem_enable),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Synchronous single-port RAM; read data holds when not reading.
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_read) mem_rdata <= ram[widx(mem_addr)];
      else          ram[widx(mem_addr)] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus reference-model prediction.
  task automatic drive(input logic rv, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic drd, input logic [31:0] da,
                       input logic [31:0] dw);
    logic force_i, exp_d, exp_i;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = rv; i_req = ir; i_addr = ia;
    d_req = dr; d_read = drd; d_addr = da; d_wdata = dw;
    if (!rv) begin
      iq.delete();
      dq.delete();
      fetch_waited = 0;
    end
    #1;
    chk("conflict", 32'(conflict), 32'(ir && dr));
    if (!rv) begin
      chk("rst_i_gnt", 32'(i_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_mem_enable", 32'(mem_enable), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
      return;
    end
    force_i = (fetch_waited == int'(LIMIT));
    exp_d = dr && !(force_i && ir);
    exp_i = ir && !exp_d;
    chk("d_gnt", 32'(d_gnt), 32'(exp_d));
    chk("i_gnt", 32'(i_gnt), 32'(exp_i));
    chk("mem_enable", 32'(mem_enable), 32'(exp_d || exp_i));
    if (exp_d) begin
      chk("mem_read", 32'(mem_read), 32'(drd));
      chk("mem_addr", mem_addr, da);
      chk("mem_wdata", mem_wdata, dw);
      e.due = cyc + 1;
      if (drd) begin
        e.data = shadow[widx(da)];
        dq.push_back(e);
      end else begin
        shadow[widx(da)] = dw;
      end
    end else if (exp_i) begin
      chk("mem_read", 32'(mem_read), 32'd1);
      chk("mem_addr", mem_addr, ia);
      chk("mem_wdata", mem_wdata, 32'd0);
      e.due = cyc + 1;
      e.data = shadow[widx(ia)];
      iq.push_back(e);
    end else begin
      chk("idle_addr", mem_addr, 32'd0);
    end
    if (ir && !exp_i) begin
      if (fetch_waited < int'(LIMIT)) fetch_waited++;
    end else begin
      fetch_waited = 0;
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0);
  endtask

  // Response monitor: pops the scoreboard whenever a port presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    end else begin
      if (i_rvalid) begin
        if (iq.size() == 0) begin
          chk("i_rvalid_unexpected", 32'(i_rvalid), 32'd0);
        end else begin
          e = iq.pop_front();
          chk("i_rvalid_cycle", cyc, e.due);
          chk("i_rdata", i_rdata, e.data);
        end
      end else begin
        chk("i_rdata_idle", i_rdata, 32'd0);
        if (iq.size() != 0 && iq[0].due <= cyc) begin
          e = iq.pop_front();
          chk("i_rvalid_missing", 32'(i_rvalid), 32'd1);
        end
      end
      if (d_rvalid) begin
        if (dq.size() == 0) begin
          chk("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
        end else begin
          e = dq.pop_front();
          chk("d_rvalid_cycle", cyc, e.due);
          chk("d_rdata", d_rdata, e.data);
        end
      end else begin
        chk("d_rdata_idle", d_rdata, 32'd0);
        if (dq.size() != 0 && dq[0].due <= cyc) begin
          e = dq.pop_front();
          chk("d_rvalid_missing", 32'(d_rvalid), 32'd1);
        end
      end
    end
  end

  initial begin
    logic        ir, dr, drd;
    logic [31:0] ia, da, dw;

    for (int i = 0; i < 256; i++) begin
      ram[i]    = (32'(i) * 32'h0101_0103) ^ 32'hA500_0000;
      shadow[i] = ram[i];
    end

    // Reset with both requesters active: nothing may be granted.
    repeat (3) drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h0);
    idle();

    // Fetch only.
    drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 32'h0, 32'h0);
    idle();

    // Load/fetch collision, then fetch proceeds.
    drive(1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 32'h100, 32'h0);
    drive(1'b1, 1'b1, 32'hC, 1'b0, 1'b1, 32'h0, 32'h0);
    idle();

    // Starvation: fetch must win on every fifth cycle.
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'(k) << 2, 32'h0);
      chk("starve_slot", 32'(i_gnt), 32'(((k + 1) % 5) == 0));
    end
    idle();

    // Store then load back.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h0);
    idle();
    chk("store_ram", ram[8], 32'hDEAD_BEEF);

    // Reset during the response cycle of a load.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h0);
    drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h40, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h44, 32'h0);
      chk("post_rst_starve", 32'(i_gnt), 32'(k == 4));
    end
    idle();

    // Randomised traffic; unmet requests are mostly held, occasionally dropped.
    ir = 0; dr = 0; drd = 1; ia = 0; da = 0; dw = 0;
    for (int k = 0; k < 400; k++) begin
      if (!ir || i_gnt || $urandom_range(0, 15) == 0) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (!dr || d_gnt || $urandom_range(0, 15) == 0) begin
        dr  = ($urandom_range(0, 2) != 0);
        drd = ($urandom_range(0, 2) != 0);
        da  = 32'($urandom_range(0, 255)) << 2;
        dw  = $urandom;
      end
      drive(1'b1, ir, ia, dr, drd, da, dw);
    end
    idle();
    idle();
    chk("drain_i", 32'(iq.size()), 32'd0);
    chk("drain_d", 32'(dq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Two-port arbiter that shares one single-ported synchronous `rv32_ram_32bit` between the CPU instruction-fetch port and the data load/store port. It sits between `rv32_cpu_top` and a unified memory in `rv32_system_top`, replacing the separate code and data RAMs. Arbitration is fixed-priority data-over-instruction, with a starvation counter that guarantees fetch progress. A small response FSM routes each one-cycle-latency read return to the port that issued it.

## Interface
- `ADDR_W`, 32, address width, passed through unchanged
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive denied instruction-request cycles before fetch is forced to win; legal range 1..15

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_req`  in  1  fetch request (level, held until granted)
- `i_addr`  in  ADDR_W  fetch address
- `i_gnt`  out  1  fetch accepted this cycle
- `i_rvalid`  out  1  `i_rdata` valid
- `i_rdata`  out  DATA_W  fetch data
- `d_req`  in  1  data request (level, held until granted)
- `d_read`  in  1  1 = load, 0 = store
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data access accepted this cycle
- `d_rvalid`  out  1  `d_rdata` valid (loads only)
- `d_rdata`  out  DATA_W  load data
- `conflict`  out  1  `i_req && d_req` this cycle (CPU stall hint)
- `mem_enable`  out  1  RAM enable
- `mem_read`  out  1  RAM read/not-write
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after an enabled read

## Operation
- Grant is combinational from the current requests and `starve_cnt`.
  - `force_i = (starve_cnt == STARVE_LIMIT)`.
  - `d_gnt = d_req && !(force_i && i_req)`.
  - `i_gnt = i_req && !d_gnt`.
- At most one grant per cycle.
- Memory drive follows the grant:
  - Data grant: `mem_enable=1`, `mem_read=d_read`, `mem_addr=d_addr`, `mem_wdata=d_wdata`.
  - Fetch grant: `mem_enable=1`, `mem_read=1`, `mem_addr=i_addr`, `mem_wdata=0`.
  - No grant: `mem_enable=0`, `mem_read=1`, address and wdata 0.
- Starvation counter `starve_cnt`:
  - Clears when `i_gnt` is high or `i_req` is low.
  - Increments when `i_req && !i_gnt`.
  - Saturates at STARVE_LIMIT; it can only reach the limit with `i_req` high.
- Response FSM `resp_owner` has states OWN_NONE, OWN_I, OWN_D. Next state each cycle:
  - OWN_I if `i_gnt`.
  - OWN_D if `d_gnt && d_read`.
  - Otherwise OWN_NONE (this covers stores and idle cycles).
- Response outputs are decoded from `resp_owner`:
  - `i_rvalid = (resp_owner==OWN_I)`, `d_rvalid = (resp_owner==OWN_D)`.
  - Both rdata outputs carry `mem_rdata` while their rvalid is high and 0 otherwise.
- Stores have no response; `d_gnt` is the completion.

## Timing
- Reset values:
  - `resp_owner=OWN_NONE`, `starve_cnt=0`.
  - `i_rvalid=d_rvalid=0`, rdata outputs 0.
  - While `rst_n` is low, all grants and `mem_enable` are forced 0.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1.
- Throughput: one access per cycle. A new grant in N+1 overlaps the response of N.
- Back-to-back data loads with fetch pending: fetch gets the grant on the (STARVE_LIMIT+1)th cycle of waiting, then the counter clears.
- Simultaneous request with `force_i` low: data wins. A lone requester is always granted the same cycle.
- Request dropped before grant: no access, no response, counter clears.
- Reset asserted mid-transaction: the pending response is discarded. No rvalid is produced after reset releases.
- Address and data are never modified; alignment is the requester's responsibility.

## Structure
- Package `rv32_mem_pkg` holds:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} mem_owner_t`.
  - Default width constants `RV32_ADDR_W=32`, `RV32_DATA_W=32`.
- Sub-module `rv32_starve_counter`: saturating counter with clear, increment and `at_limit` output, parameterised on LIMIT. Its width is `$clog2(LIMIT+1)`.
- Everything else (grant logic, memory mux, response FSM) is flat in `rv32_mem_arbiter`.

## Test plan
- **Fetch only:** `i_req=1`, `i_addr` 0x0,0x4,0x8 → `i_gnt` every cycle; `i_rvalid` one cycle later with RAM contents; `d_rvalid` stays 0.
- **Load/fetch collision:** `d_req=1`, `d_read=1`, `d_addr=0x100` together with `i_req=1` → `d_gnt=1`, `i_gnt=0`, `conflict=1`; next cycle `d_rvalid=1`, `d_rdata=mem[0x100]`, then fetch granted.
- **Starvation:** continuous loads plus continuous `i_req`, STARVE_LIMIT=4 → `i_gnt` on cycles 5, 10, 15…; `d_gnt` low on exactly those cycles.
- **Store:** `d_read=0`, `d_addr=0x20`, `d_wdata=0xDEADBEEF` → `mem_enable=1`, `mem_read=0`, `d_gnt=1`, no rvalid. A load of 0x20 then returns 0xDEADBEEF.
- **Reset mid-read:** grant a load, assert `rst_n=0` in the response cycle → `d_rvalid`, `starve_cnt`, grants and `mem_enable` all 0 immediately. After release, the first access behaves as from idle.
